// File: rtl/cc_bus_sequencer.sv
// Master-side sequencer for a shared parallel bus driving a CC_Bidir pin block.
// Optional wait-pin support is enabled by defining CC_BUS_WAIT_PIN_EN.
module cc_bus_sequencer #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 8,
    parameter int WAIT_CYCLES = 2,
    parameter int TURNAROUND  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic                  wr,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  ready,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic                  bus_cs_n,
    output logic                  bus_rd_n,
    output logic                  bus_wr_n,
    output logic                  bus_sel_in,
    output logic [DATA_WIDTH-1:0] bus_out,
    input  logic [DATA_WIDTH-1:0] bus_in
`ifdef CC_BUS_WAIT_PIN_EN
    ,
    input  logic                  bus_wait
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_HOLD   = 3'd3,
        ST_TURN   = 3'd4
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(WAIT_CYCLES);
    localparam logic [7:0] TURN_LAST = (TURNAROUND > 0) ? 8'(TURNAROUND - 1) : 8'd0;

    state_t                  state_r;
    state_t                  state_s;
    logic [7:0]              cnt_r;
    logic [7:0]              cnt_s;
    logic [7:0]              cnt_adv_s;
    logic                    op_wr_r;
    logic                    op_wr_s;
    logic                    wait_s;
    logic                    busy_s;
    logic                    ready_s;
    logic                    done_s;
    logic [DATA_WIDTH-1:0]   rdata_s;
    logic [ADDR_WIDTH-1:0]   bus_addr_s;
    logic                    bus_cs_n_s;
    logic                    bus_rd_n_s;
    logic                    bus_wr_n_s;
    logic                    bus_sel_in_s;
    logic [DATA_WIDTH-1:0]   bus_out_s;

`ifdef CC_BUS_WAIT_PIN_EN
    assign wait_s = bus_wait;
`else
    assign wait_s = 1'b0;
`endif

    // Next-state, counter and next-output computation; outputs are decoded from the next state
    always_comb begin
        state_s    = state_r;
        cnt_adv_s  = cnt_r;
        op_wr_s    = op_wr_r;
        rdata_s    = rdata;
        bus_addr_s = bus_addr;
        bus_out_s  = bus_out;

        case (state_r)
            ST_IDLE: begin
                if (req) begin
                    state_s    = ST_SETUP;
                    op_wr_s    = wr;
                    bus_addr_s = addr;
                    if (wr) begin
                        bus_out_s = wdata;
                    end else begin
                        bus_out_s = bus_out;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_s = ST_ACCESS;
            end
            ST_ACCESS: begin
                // The counter saturates at WAIT_LAST so an external wait can stretch the strobe
                if ((cnt_r == WAIT_LAST) && !wait_s) begin
                    state_s = ST_HOLD;
                    if (!op_wr_r) begin
                        rdata_s = bus_in;
                    end else begin
                        rdata_s = rdata;
                    end
                end else begin
                    state_s = ST_ACCESS;
                    if (cnt_r == WAIT_LAST) begin
                        cnt_adv_s = cnt_r;
                    end else begin
                        cnt_adv_s = cnt_r + 8'd1;
                    end
                end
            end
            ST_HOLD: begin
                if (TURNAROUND == 0) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_TURN;
                end
            end
            ST_TURN: begin
                if (cnt_r == TURN_LAST) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s   = ST_TURN;
                    cnt_adv_s = cnt_r + 8'd1;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        if (state_s != state_r) begin
            cnt_s = 8'd0;
        end else begin
            cnt_s = cnt_adv_s;
        end

        busy_s       = (state_s == ST_SETUP) || (state_s == ST_ACCESS) || (state_s == ST_HOLD);
        ready_s      = (state_s == ST_IDLE);
        done_s       = (state_s == ST_HOLD);
        bus_cs_n_s   = !busy_s;
        bus_rd_n_s   = !((state_s == ST_ACCESS) && !op_wr_s);
        bus_wr_n_s   = !((state_s == ST_ACCESS) && op_wr_s);
        // The FPGA drives the data pins only while a write owns the bus
        bus_sel_in_s = !(busy_s && op_wr_s);
    end

    // State, counter and registered bus outputs; reset releases the bus immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 8'd0;
            op_wr_r    <= 1'b0;
            ready      <= 1'b1;
            done       <= 1'b0;
            rdata      <= '0;
            bus_addr   <= '0;
            bus_cs_n   <= 1'b1;
            bus_rd_n   <= 1'b1;
            bus_wr_n   <= 1'b1;
            bus_sel_in <= 1'b1;
            bus_out    <= '0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            op_wr_r    <= op_wr_s;
            ready      <= ready_s;
            done       <= done_s;
            rdata      <= rdata_s;
            bus_addr   <= bus_addr_s;
            bus_cs_n   <= bus_cs_n_s;
            bus_rd_n   <= bus_rd_n_s;
            bus_wr_n   <= bus_wr_n_s;
            bus_sel_in <= bus_sel_in_s;
            bus_out    <= bus_out_s;
        end
    end

endmodule

// File: tb/tb_cc_bus_sequencer.sv
// Randomized bench for cc_bus_sequencer: three instances with different timing share
// one stimulus stream and are each compared every cycle against a phase-offset model.
module tb_cc_bus_sequencer;

    localparam int W0 = 2;
    localparam int T0 = 1;
    localparam int W1 = 0;
    localparam int T1 = 0;
    localparam int W2 = 1;
    localparam int T2 = 3;

    typedef struct {
        int          k;        // cycles since accept edge, 0 = idle
        int          acc_end;  // value of k in the last strobe cycle
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  out;
        logic [7:0]  rdata;
    } mdl_t;

    logic        clk;
    logic        reset;
    logic        req;
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  bus_in;
    logic        bus_wait;

    logic [2:0]       rdy, dn, cs, rdn, wrn, sel;
    logic [2:0][7:0]  rd, bo;
    logic [2:0][15:0] ba;

    mdl_t m [3];
    int   wc [3];
    int   tc [3];
    int   n_checks;
    int   n_errors;
    int   rd_low;

    cc_bus_sequencer #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .WAIT_CYCLES(W0), .TURNAROUND(T0)) u0 (
        .clk(clk), .reset(reset), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
        .ready(rdy[0]), .done(dn[0]), .rdata(rd[0]), .bus_addr(ba[0]), .bus_cs_n(cs[0]),
        .bus_rd_n(rdn[0]), .bus_wr_n(wrn[0]), .bus_sel_in(sel[0]), .bus_out(bo[0]),
        .bus_in(bus_in)
`ifdef CC_BUS_WAIT_PIN_EN
        , .bus_wait(bus_wait)
`endif
    );

    cc_bus_sequencer #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .WAIT_CYCLES(W1), .TURNAROUND(T1)) u1 (
        .clk(clk), .reset(reset), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
        .ready(rdy[1]), .done(dn[1]), .rdata(rd[1]), .bus_addr(ba[1]), .bus_cs_n(cs[1]),
        .bus_rd_n(rdn[1]), .bus_wr_n(wrn[1]), .bus_sel_in(sel[1]), .bus_out(bo[1]),
        .bus_in(bus_in)
`ifdef CC_BUS_WAIT_PIN_EN
        , .bus_wait(bus_wait)
`endif
    );

    cc_bus_sequencer #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .WAIT_CYCLES(W2), .TURNAROUND(T2)) u2 (
        .clk(clk), .reset(reset), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
        .ready(rdy[2]), .done(dn[2]), .rdata(rd[2]), .bus_addr(ba[2]), .bus_cs_n(cs[2]),
        .bus_rd_n(rdn[2]), .bus_wr_n(wrn[2]), .bus_sel_in(sel[2]), .bus_out(bo[2]),
        .bus_in(bus_in)
`ifdef CC_BUS_WAIT_PIN_EN
        , .bus_wait(bus_wait)
`endif
    );

    // Free-running 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic mdl_t m_reset();
        mdl_t r;
        r.k = 0; r.acc_end = 0; r.wr = 1'b0;
        r.addr = 16'h0000; r.out = 8'h00; r.rdata = 8'h00;
        return r;
    endfunction

    // One clock edge of the transaction model, from the published phase lengths
    function automatic mdl_t m_step(input mdl_t mi, input int w, input int t, input logic rst,
                                    input logic rq, input logic rw, input logic [15:0] a,
                                    input logic [7:0] d, input logic [7:0] bi, input logic bw);
        mdl_t n;
        n = mi;
        if (rst) return m_reset();
        if (n.k == 0) begin
            if (rq) begin
                n.k = 1; n.acc_end = 2 + w; n.wr = rw; n.addr = a;
                if (rw) n.out = d;
            end
            return n;
        end
        if (n.k == n.acc_end) begin
            if (bw) n.acc_end++;
            else if (!n.wr) n.rdata = bi;
        end
        n.k++;
        if (n.k > n.acc_end + 1 + t) n.k = 0;
        return n;
    endfunction

    task automatic check_dut(input int i);
        mdl_t e;
        logic busy, acc, hold;
        e    = m[i];
        busy = (e.k >= 1) && (e.k <= e.acc_end + 1);
        acc  = (e.k >= 2) && (e.k <= e.acc_end);
        hold = (e.k != 0) && (e.k == e.acc_end + 1);
        check_eq($sformatf("u%0d.ready", i),    32'(rdy[i]), 32'(e.k == 0));
        check_eq($sformatf("u%0d.done", i),     32'(dn[i]),  32'(hold));
        check_eq($sformatf("u%0d.cs_n", i),     32'(cs[i]),  32'(!busy));
        check_eq($sformatf("u%0d.rd_n", i),     32'(rdn[i]), 32'(!(acc && !e.wr)));
        check_eq($sformatf("u%0d.wr_n", i),     32'(wrn[i]), 32'(!(acc && e.wr)));
        check_eq($sformatf("u%0d.sel_in", i),   32'(sel[i]), 32'(!(busy && e.wr)));
        check_eq($sformatf("u%0d.bus_addr", i), 32'(ba[i]),  32'(e.addr));
        check_eq($sformatf("u%0d.bus_out", i),  32'(bo[i]),  32'(e.out));
        check_eq($sformatf("u%0d.rdata", i),    32'(rd[i]),  32'(e.rdata));
    endtask

    task automatic tick();
        @(posedge clk);
        for (int i = 0; i < 3; i++)
            m[i] = m_step(m[i], wc[i], tc[i], reset, req, wr, addr, wdata, bus_in, bus_wait);
        @(negedge clk);
        for (int i = 0; i < 3; i++) check_dut(i);
    endtask

    task automatic request(input logic rw, input logic [15:0] a, input logic [7:0] d, input int drain);
        req = 1'b1; wr = rw; addr = a; wdata = d;
        tick();
        req = 1'b0; wr = 1'b0; addr = 16'h0000; wdata = 8'h00;
        for (int c = 0; c < drain; c++) tick();
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        wc = '{W0, W1, W2};
        tc = '{T0, T1, T2};
        for (int i = 0; i < 3; i++) m[i] = m_reset();
        reset = 1'b1; req = 1'b0; wr = 1'b0; addr = 16'h0000; wdata = 8'h00;
        bus_in = 8'h00; bus_wait = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Directed write and read with default timing on u0
        request(1'b1, 16'h1234, 8'hA5, 10);
        bus_in = 8'h3C;
        request(1'b0, 16'h0042, 8'h77, 10);

        // Back-to-back: req held high, write first then reads
        req = 1'b1; wr = 1'b1; addr = 16'h0101; wdata = 8'h5A; bus_in = 8'hC3;
        tick();
        wr = 1'b0; addr = 16'h0202;
        for (int c = 0; c < 20; c++) tick();
        req = 1'b0;
        for (int c = 0; c < 10; c++) tick();

        // Reset in cycle 3 of a write, between clock edges
        request(1'b1, 16'hBEEF, 8'h99, 0);
        for (int c = 0; c < 10 && m[0].k != 3; c++) tick();
        reset = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) m[i] = m_reset();
        for (int i = 0; i < 3; i++) check_dut(i);
        tick();
        reset = 1'b0;
        request(1'b1, 16'hCAFE, 8'h3D, 10);

        // Requests and address changes while busy are ignored
        bus_in = 8'h81;
        request(1'b0, 16'h5555, 8'h00, 0);
        req = 1'b1; addr = 16'hAAAA; wr = 1'b1; tick();
        req = 1'b0; addr = 16'h0F0F; tick();
        wr = 1'b0;
        for (int c = 0; c < 10; c++) tick();

`ifdef CC_BUS_WAIT_PIN_EN
        // Wait pin held for four extra strobe cycles on u2 (WAIT_CYCLES=1)
        rd_low = 0;
        request(1'b0, 16'h0BEE, 8'h00, 0);
        for (int c = 0; c < 14; c++) begin
            bus_wait = (m[2].k >= 3) && (m[2].k <= 6);
            bus_in   = 8'($urandom);
            tick();
            if (rdn[2] == 1'b0) rd_low++;
        end
        bus_wait = 1'b0;
        check_eq("u2.rd_low_cycles", 32'(rd_low), 32'd6);
        for (int c = 0; c < 10; c++) tick();
`endif

        // Randomized traffic with occasional resets
        for (int c = 0; c < 2000; c++) begin
            req    = ($urandom_range(0, 2) == 0);
            wr     = 1'($urandom);
            addr   = 16'($urandom);
            wdata  = 8'($urandom);
            bus_in = 8'($urandom);
            reset  = ($urandom_range(0, 299) == 0);
`ifdef CC_BUS_WAIT_PIN_EN
            bus_wait = ($urandom_range(0, 3) == 0);
`else
            bus_wait = 1'b0;
`endif
            tick();
        end
        reset = 1'b0; req = 1'b0; bus_wait = 1'b0;
        for (int c = 0; c < 12; c++) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
